// File: rtl/load_stream_arbiter.sv
// load_stream_arbiter
//   Merges the IFM, WGT and BIAS load streams onto one tagged load bus. The
//   arbiter grants one source at a time in round-robin order. A grant lasts
//   for one burst: it ends on the source's last beat or on the BURST_LEN-th
//   beat, whichever comes first. Each accepted beat is registered, and the
//   register also holds the 2-bit channel tag that the buffer demux decodes.
//
// Ports
//   clk, rst                          clock (rising edge), async active-high reset
//   ifm_data/valid/last, ifm_ready    IFM source stream
//   wgt_data/valid/last, wgt_ready    WGT source stream
//   bias_data/valid/last, bias_ready  BIAS source stream
//   out_data/sel/valid/last           registered merged beat + channel tag
//   out_ready                         downstream accept
//   busy                              high while a grant is open or a beat is held
module load_stream_arbiter #(
  parameter int         DATA_WIDTH = 32,
  parameter int         BURST_LEN  = 16,
  parameter logic [1:0] IFM        = 2'b01,
  parameter logic [1:0] WGT        = 2'b10,
  parameter logic [1:0] BIAS       = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ifm_data,
  input  logic                  ifm_valid,
  input  logic                  ifm_last,
  output logic                  ifm_ready,
  input  logic [DATA_WIDTH-1:0] wgt_data,
  input  logic                  wgt_valid,
  input  logic                  wgt_last,
  output logic                  wgt_ready,
  input  logic [DATA_WIDTH-1:0] bias_data,
  input  logic                  bias_valid,
  input  logic                  bias_last,
  output logic                  bias_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_sel,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                  state_q;
  logic [1:0]              grant_q;
  logic [1:0]              rr_q;
  logic [CW-1:0]           beat_cnt_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [1:0]              out_sel_q;
  logic                    out_valid_q;
  logic                    out_last_q;

  logic [1:0]              pick_d;
  logic [1:0]              rr_d;
  logic                    slot_free;
  logic                    granted;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    accept;
  logic                    cap_hit;
  logic                    burst_end;

  // The output register can take a new beat when it is empty or is being
  // drained in this same cycle.
  assign slot_free = ~out_valid_q | out_ready;
  assign granted   = (state_q == S_GRANT);

  assign ifm_ready  = granted && (grant_q == IFM)  && slot_free;
  assign wgt_ready  = granted && (grant_q == WGT)  && slot_free;
  assign bias_ready = granted && (grant_q == BIAS) && slot_free;

  // Select the granted source.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    case (grant_q)
      IFM:  begin g_valid = ifm_valid;  g_last = ifm_last;  g_data = ifm_data;  end
      WGT:  begin g_valid = wgt_valid;  g_last = wgt_last;  g_data = wgt_data;  end
      BIAS: begin g_valid = bias_valid; g_last = bias_last; g_data = bias_data; end
      default: ;
    endcase
  end

  assign accept    = granted & g_valid & slot_free;
  assign cap_hit   = (beat_cnt_q + CW'(1)) == BURST_LEN_C;
  assign burst_end = accept & (g_last | cap_hit);

  // Pick the first valid source in cyclic order, starting at the rr pointer.
  // 2'b00 means that no source is requesting.
  always_comb begin
    pick_d = 2'b00;
    case (rr_q)
      IFM: begin
        if      (ifm_valid)  pick_d = IFM;
        else if (wgt_valid)  pick_d = WGT;
        else if (bias_valid) pick_d = BIAS;
      end
      WGT: begin
        if      (wgt_valid)  pick_d = WGT;
        else if (bias_valid) pick_d = BIAS;
        else if (ifm_valid)  pick_d = IFM;
      end
      default: begin
        if      (bias_valid) pick_d = BIAS;
        else if (ifm_valid)  pick_d = IFM;
        else if (wgt_valid)  pick_d = WGT;
      end
    endcase
  end

  // After a burst, the pointer moves to the channel that follows the one
  // just served.
  always_comb begin
    case (grant_q)
      IFM:     rr_d = WGT;
      WGT:     rr_d = BIAS;
      default: rr_d = IFM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      rr_q        <= IFM;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_d != 2'b00) begin
            grant_q    <= pick_d;
            beat_cnt_q <= '0;
            state_q    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (burst_end) begin
              state_q <= S_IDLE;
              rr_q    <= rr_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Output stage: load the register on acceptance. Empty it when the
      // downstream drains it and no new beat arrives. Otherwise hold it.
      if (accept) begin
        out_data_q  <= g_data;
        out_sel_q   <= grant_q;
        out_valid_q <= 1'b1;
        out_last_q  <= g_last | cap_hit;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_sel_q   <= 2'b00;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = granted | out_valid_q;

endmodule

// File: tb/tb_load_stream_arbiter.sv
module tb_load_stream_arbiter;

  localparam int DW = 32;
  localparam int BL = 4;

  typedef struct packed {
    logic [1:0]    tag;
    logic [DW-1:0] data;
    logic          last;
  } obeat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data  [3];
  logic          s_valid [3];
  logic          s_last  [3];
  logic          ifm_ready, wgt_ready, bias_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_valid, out_last, out_ready, busy;

  int tests = 0;
  int fails = 0;

  // Per-channel source contents: {last, data} beats, plus a read pointer.
  logic [DW:0] src_mem [3][64];
  int          src_len  [3];
  int          src_head [3];
  obeat_t      exp_q[$];
  int          model_rr;

  always #5 clk = ~clk;

  load_stream_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .ifm_data(s_data[0]),  .ifm_valid(s_valid[0]),  .ifm_last(s_last[0]),  .ifm_ready(ifm_ready),
    .wgt_data(s_data[1]),  .wgt_valid(s_valid[1]),  .wgt_last(s_last[1]),  .wgt_ready(wgt_ready),
    .bias_data(s_data[2]), .bias_valid(s_valid[2]), .bias_last(s_last[2]), .bias_ready(bias_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [2:0] readies();
    return {bias_ready, wgt_ready, ifm_ready};
  endfunction

  // Fill the sources with random transfers. Then derive the expected output
  // stream from the arbitration rules. Every non-empty source counts as
  // requesting. Each burst serves the first requester from the pointer, for
  // up to BL beats or until the source's last beat.
  task automatic build_round();
    int h[3];
    int ch, n, ntr, len;
    bit done;
    logic [DW:0] b;
    obeat_t ob;
    for (int c = 0; c < 3; c++) begin
      src_len[c] = 0;
      src_head[c] = 0;
      ntr = $urandom_range(0, 3);
      for (int t = 0; t < ntr; t++) begin
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) begin
          src_mem[c][src_len[c]] = {(k == len - 1), DW'($urandom)};
          src_len[c]++;
        end
      end
      h[c] = 0;
    end
    while (h[0] < src_len[0] || h[1] < src_len[1] || h[2] < src_len[2]) begin
      ch = model_rr;
      while (h[ch] >= src_len[ch]) ch = (ch + 1) % 3;
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = src_mem[ch][h[ch]];
        h[ch]++;
        n++;
        done = b[DW] || (n == BL);
        ob.tag  = 2'(ch + 1);
        ob.data = b[DW-1:0];
        ob.last = done;
        exp_q.push_back(ob);
      end
      model_rr = (ch + 1) % 3;
    end
  endtask

  function automatic bit sources_pending();
    return (src_head[0] < src_len[0]) || (src_head[1] < src_len[1]) || (src_head[2] < src_len[2]);
  endfunction

  // Apply random backpressure cycle by cycle, and score every output beat.
  task automatic run_round();
    int cyc;
    logic pv, pr;
    logic [35:0] prev_vec;
    logic [2:0] rdy;
    obeat_t got;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
    prev_vec = '0;
    while ((exp_q.size() > 0 || sources_pending()) && cyc < 3000) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (src_head[c] < src_len[c]) begin
          s_valid[c] = 1'b1;
          s_data[c]  = src_mem[c][src_head[c]][DW-1:0];
          s_last[c]  = src_mem[c][src_head[c]][DW];
        end else begin
          s_valid[c] = 1'b0;
          s_data[c]  = '0;
          s_last[c]  = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = readies();
      if (pv && !pr)
        check("hold", {out_valid, out_sel, out_last, out_data}, {1'b1, prev_vec[34:0]});
      if (!out_valid)
        check("idle_sel", out_sel, 2'b00);
      if (out_valid)
        check("busy_when_valid", busy, 1'b1);
      check("ready_onehot", ($countones(rdy) <= 1), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", out_valid, 1'b0);
        end else begin
          got = exp_q.pop_front();
          check("beat", {out_sel, out_last, out_data}, {got.tag, got.last, got.data});
        end
      end
      for (int c = 0; c < 3; c++)
        if (s_valid[c] && rdy[c]) src_head[c]++;
      pv = out_valid;
      pr = out_ready;
      prev_vec = {out_valid, out_sel, out_last, out_data};
      cyc++;
    end
    check("round_drained", exp_q.size(), 0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) s_valid[c] = 1'b0;
    out_ready = 1'b1;
    #1;
    check("round_idle_busy", {busy, out_valid}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rdy;
    bit seen;
    for (int c = 0; c < 3; c++) begin
      s_valid[c] = 1'b0;
      s_data[c]  = '0;
      s_last[c]  = 1'b0;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #12;
    check("reset_outputs",
          {out_valid, out_sel, out_last, busy, ifm_ready, wgt_ready, bias_ready, out_data}, 0);

    // Single IFM beat. The beat appears two cycles after valid rises and
    // stays for exactly one cycle.
    @(negedge clk);
    rst = 1'b0;
    s_valid[0] = 1'b1; s_data[0] = 32'hA5A5A5A5; s_last[0] = 1'b1;
    out_ready = 1'b1;
    #1;
    check("single_idle_ready", readies(), 3'b000);
    @(negedge clk); #1;
    check("single_grant", {readies(), out_valid, busy}, {3'b001, 1'b0, 1'b1});
    @(negedge clk);
    s_valid[0] = 1'b0;
    #1;
    check("single_beat", {out_valid, out_sel, out_last, out_data}, {1'b1, 2'b01, 1'b1, 32'hA5A5A5A5});
    @(negedge clk); #1;
    check("single_drop", {out_valid, out_sel, busy}, {1'b0, 2'b00, 1'b0});
    model_rr = 1;

    // Random rounds with backpressure, scored against the burst model.
    for (int r = 0; r < 6; r++) begin
      build_round();
      run_round();
    end

    // A lone WGT beat leaves the pointer at BIAS.
    @(negedge clk);
    s_valid[1] = 1'b1; s_data[1] = 32'h55; s_last[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (wgt_ready) seen = 1'b1;
      @(negedge clk);
    end
    s_valid[1] = 1'b0;
    check("wgt_single_granted", seen, 1'b1);
    #1;
    check("wgt_single_beat", {out_valid, out_sel, out_data}, {1'b1, 2'b10, 32'h55});
    @(negedge clk);

    // Apply an asynchronous reset on the 2nd BIAS beat of a burst.
    s_valid[2] = 1'b1; s_data[2] = 32'h1; s_last[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (bias_ready) seen = 1'b1;
      @(negedge clk);
    end
    check("bias_granted", seen, 1'b1);
    s_data[2] = 32'h2;
    #1;
    check("bias_beat1_out", {out_valid, out_sel, out_data, bias_ready}, {1'b1, 2'b11, 32'h1, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {out_valid, out_sel, out_last, busy, ifm_ready, wgt_ready, bias_ready, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    s_valid[0] = 1'b1; s_data[0] = 32'hC0DE; s_last[0] = 1'b1;
    s_data[2] = 32'h3;
    #1;
    check("post_reset_idle", readies(), 3'b000);
    @(negedge clk); #1;
    rdy = readies();
    check("post_reset_ifm_first", rdy, 3'b001);
    @(negedge clk);
    s_valid[0] = 1'b0;
    s_valid[2] = 1'b0;
    #1;
    check("post_reset_ifm_beat", {out_valid, out_sel, out_data}, {1'b1, 2'b01, 32'hC0DE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_stream_arbiter.md
Name: load_stream_arbiter

Overview:
- Merges the three load streams (IFM, WGT, BIAS) onto the single tagged load bus that feeds the accelerator's 1-to-3 buffer demultiplexer.
- Arbitrates round-robin in bursts.
- Registers each accepted beat and drives a 2-bit select tag using the same encoding the demux decodes, so the demux routes each beat to the correct buffer.
- Uses valid/ready handshakes on all sides.

Parameters:
- DATA_WIDTH, 32: width of all data buses.
- BURST_LEN, 16: maximum beats per grant; must be ≥1.
- IFM, 2'b01: tag value for the IFM channel.
- WGT, 2'b10: tag value for the WGT channel.
- BIAS, 2'b11: tag value for the BIAS channel. Tag 2'b00 means idle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifm_data  in  DATA_WIDTH  IFM source beat.
- ifm_valid  in  1  IFM beat valid.
- ifm_last  in  1  last beat of the IFM transfer.
- ifm_ready  out  1  IFM beat accepted when valid&ready.
- wgt_data / wgt_valid / wgt_last / wgt_ready  same as IFM, WGT channel.
- bias_data / bias_valid / bias_last / bias_ready  same as IFM, BIAS channel.
- out_data  out  DATA_WIDTH  registered merged beat.
- out_sel  out  2  channel tag of out_data; 2'b00 when out_valid=0.
- out_valid  out  1  output beat valid.
- out_last  out  1  final beat of the current burst.
- out_ready  in  1  downstream accepts the beat when out_valid&out_ready.
- busy  out  1  high while in GRANT or while out_valid=1.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, rr pointer=IFM, beat_cnt=0, out_valid=0, out_data=0, out_sel=2'b00, out_last=0, busy=0, all *_ready=0. Reset mid-burst discards the held output beat; there is no resume.
- FSM states: IDLE, GRANT.
- IDLE:
  - *_ready=0.
  - If any source is valid, grant the first valid channel found in cyclic order IFM→WGT→BIAS, starting at the rr pointer. Latch the grant, clear beat_cnt, go to GRANT next cycle.
  - If no source is valid, stay in IDLE.
- GRANT, ready: only the granted source sees ready = ~out_valid | out_ready (single-register skid-free stage). The other two readies are 0.
- GRANT, acceptance (src valid&ready):
  - Next cycle: out_data=src data, out_sel=tag of the granted channel, out_valid=1.
  - beat_cnt increments.
  - out_last = src_last | (beat_cnt+1 == BURST_LEN).
- Burst end: acceptance of a beat with src_last=1, or the BURST_LEN-th beat.
  - Go to IDLE the next cycle.
  - Set the rr pointer to the channel after the granted one (BIAS wraps to IFM).
  - The held output beat still drains normally.
- Latency: 1 cycle from source acceptance to out_valid. Minimum one idle arbitration cycle between bursts, so peak throughput is BURST_LEN beats per BURST_LEN+1 cycles.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_sel and out_last are stable. When out_ready=1 and no new acceptance occurs, out_valid→0 and out_sel→2'b00.
- Back-to-back: out_ready=1 with a continuously valid source gives one beat per cycle with no bubble.
- Granted source drops valid mid-burst: grant is held, beat_cnt is unchanged, no timeout.
- Other sources raising valid mid-burst do not preempt the current grant.
- beat_cnt width is $clog2(BURST_LEN+1). The counter never exceeds BURST_LEN.
- The rr pointer advances only on burst end, never in IDLE without a grant.
- Simultaneous requests: resolved purely by the rr pointer.
- src_last=1 on the same beat where beat_cnt hits BURST_LEN: a single burst end, out_last=1 once.
- Source data and last are sampled only on acceptance. Valid must not be withdrawn before acceptance; this is a source requirement and is not checked.

Test Plan:
- Reset then single IFM beat 0xA5A5A5A5, last=1, out_ready=1 → out_sel=01, out_data=0xA5A5A5A5, out_last=1, out_valid=1 for exactly 1 cycle, 2 cycles after ifm_valid rises; back to IDLE.
- All three valid from reset, each sending 3 beats with last on beat 3, out_ready=1 → output tag order 01,01,01,10,10,10,11,11,11; one gap cycle between bursts; out_last on beats 3, 6 and 9.
- BURST_LEN=4, WGT continuously valid for 10 beats with no last, IFM idle → bursts of 4, 4, 2 beats. The 2-beat burst needs WGT to assert last on beat 10. out_last on beats 4, 8 and 10. A WGT regrant follows each burst because no other source is valid.
- out_ready held 0 for 5 cycles mid-burst → out_data and out_sel stay stable, bias_ready=0, no beat lost or duplicated; the sequence 0x1,0x2,0x3 is received in order.
- Round-robin fairness: IFM and BIAS both always valid, bursts of 2 → tags alternate 01,01,11,11,01,01,…; WGT is never granted while wgt_valid=0.
- rst asserted asynchronously mid-burst on the 2nd of 4 BIAS beats → all outputs go to reset values immediately. After release, a new IFM request is granted first (pointer reset to IFM).
